// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: stalls fetch, drains the pipe, pushes PC/flags, loads the ISR vector
module interrupt_sequencer #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt_signal,
  input  logic [31:0] pc_in,
  input  logic [3:0]  flags_in,
  input  logic        mem_ready,
  output logic        stall_fetch,
  output logic        inject_valid,
  output logic        mem_push,
  output logic        mem_read,
  output logic [15:0] push_data,
  output logic [31:0] mem_addr,
  output logic        pc_choose_memory,
  output logic        pc_load,
  output logic        int_ack,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, LOAD_VEC, RESUME} state_t;
  state_t      r_state, w_next;
  logic        r_prev, r_pending;
  logic [3:0]  r_cnt, r_flags;
  logic [31:0] r_ret_pc;
  logic        w_edge, w_start;
  assign w_edge  = interrupt_signal & ~r_prev;
  assign w_start = (r_state == IDLE) && r_pending;
  assign pc_load = (r_state == LOAD_VEC) && mem_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = r_pending ? DRAIN : IDLE;
      DRAIN:    w_next = (r_cnt == 4'd0) ? PUSH_HI : DRAIN;
      PUSH_HI:  w_next = mem_ready ? PUSH_LO : PUSH_HI;
      PUSH_LO:  w_next = mem_ready ? PUSH_FL : PUSH_LO;
      PUSH_FL:  w_next = mem_ready ? LOAD_VEC : PUSH_FL;
      LOAD_VEC: w_next = mem_ready ? RESUME : LOAD_VEC;
      RESUME:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // Outputs are registered from the next state, so they track the state register exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_prev           <= 1'b0;
      r_pending        <= 1'b0;
      r_cnt            <= 4'd0;
      r_flags          <= 4'd0;
      r_ret_pc         <= 32'd0;
      stall_fetch      <= 1'b0;
      inject_valid     <= 1'b0;
      mem_push         <= 1'b0;
      mem_read         <= 1'b0;
      push_data        <= 16'd0;
      mem_addr         <= 32'd0;
      pc_choose_memory <= 1'b0;
      int_ack          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_prev    <= interrupt_signal;
      r_pending <= w_edge | (r_pending & ~w_start);
      if (w_start) begin
        r_cnt    <= 4'(DRAIN_CYCLES - 1);
        r_ret_pc <= pc_in;
        r_flags  <= flags_in;
      end else if (r_state == DRAIN && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      stall_fetch      <= w_next inside {DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, LOAD_VEC};
      inject_valid     <= w_next inside {PUSH_HI, PUSH_LO, PUSH_FL, LOAD_VEC};
      mem_push         <= w_next inside {PUSH_HI, PUSH_LO, PUSH_FL};
      mem_read         <= w_next == LOAD_VEC;
      pc_choose_memory <= w_next == LOAD_VEC;
      mem_addr         <= (w_next == LOAD_VEC) ? VECTOR_ADDR : 32'd0;
      push_data        <= (w_next == PUSH_HI) ? r_ret_pc[31:16] :
                          (w_next == PUSH_LO) ? r_ret_pc[15:0] :
                          (w_next == PUSH_FL) ? {12'd0, r_flags} : 16'd0;
      int_ack          <= w_next == RESUME;
      busy             <= w_next != IDLE;
    end
  end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle controller that sequences hardware-interrupt entry for the pipelined processor. It sits beside the decode stage. When an interrupt edge arrives it stalls fetch and lets in-flight instructions drain. It then injects three push operations (PC high, PC low, flags) into the memory stage, loads the new PC from the interrupt vector location, and releases the pipeline. Injected operations replace decoder control outputs while `inject_valid` is high.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN before the first push. Legal range 1–15.
- `VECTOR_ADDR`, default 32'h0000_0000: memory address holding the ISR start PC.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `interrupt_signal`, input, 1: interrupt request; its rising edge is detected synchronously.
- `pc_in`, input, 32: PC of the next unexecuted instruction, i.e. the return address.
- `flags_in`, input, 4: current flag register contents.
- `mem_ready`, input, 1: memory stage accepted the current injected operation this cycle.
- `stall_fetch`, output, 1: freezes PC and the fetch/decode pipeline register.
- `inject_valid`, output, 1: injected control overrides decoder control outputs.
- `mem_push`, output, 1: injected stack push.
- `mem_read`, output, 1: injected memory read, used for the vector fetch.
- `push_data`, output, 16: data for the current push.
- `mem_addr`, output, 32: address for the vector read.
- `pc_choose_memory`, output, 1: PC mux selects memory read data.
- `pc_load`, output, 1: one-cycle PC write strobe.
- `int_ack`, output, 1: one-cycle pulse when the ISR entry is complete.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Edge detector:
  - `int_prev` is a register of `interrupt_signal`.
  - `int_edge` = `interrupt_signal & ~int_prev`.
- Pending latch:
  - `int_pending` is set on `int_edge`.
  - It is cleared on the IDLE→DRAIN transition.
  - If set and clear occur in the same cycle, set wins: pending stays 1 and a second entry follows.
- State machine: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, LOAD_VEC, RESUME.
- IDLE:
  - Moves to DRAIN when `int_pending`=1.
  - On that transition, captures `ret_pc`←`pc_in` and `saved_flags`←`flags_in`, and loads the drain counter with `DRAIN_CYCLES-1`.
- DRAIN:
  - Counter decrements each cycle.
  - Moves to PUSH_HI on the cycle in which the counter reads 0.
- PUSH_HI, PUSH_LO, PUSH_FL:
  - Each state drives `inject_valid`=1 and `mem_push`=1.
  - `push_data` is `ret_pc[31:16]`, `ret_pc[15:0]` and `{12'b0, saved_flags}` respectively.
  - The state holds until `mem_ready`=1 is sampled, then advances.
- LOAD_VEC:
  - Drives `inject_valid`=1, `mem_read`=1, `mem_addr`=`VECTOR_ADDR` and `pc_choose_memory`=1.
  - When `mem_ready`=1 is sampled, `pc_load` is high in that same cycle (combinational from state & `mem_ready`), and the state moves to RESUME.
- RESUME: one cycle with `int_ack`=1, then goes to IDLE unconditionally.
- Output levels:
  - `stall_fetch`=1 in DRAIN through LOAD_VEC, and 0 in IDLE and RESUME.
  - `busy`=1 in every state except IDLE.
  - `mem_push`, `mem_read` and `pc_choose_memory` are 0 outside the states listed above.
  - `push_data` and `mem_addr` are 0 when not in use.
- Edges arriving while `busy`=1 are not lost. They set `int_pending`, so another full entry starts after at least one IDLE cycle.
- A level held high produces exactly one entry; a new entry needs a fresh rising edge.
- Reset mid-sequence:
  - Forces IDLE immediately and clears `int_pending`, `int_prev`, counter, `ret_pc` and `saved_flags`.
  - Any partial stack pushes are abandoned.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Registered outputs: all outputs except `pc_load` are decoded from the state register (Moore).
- Edge to DRAIN:
  - Edge sampled at edge N; `int_pending`=1 after N.
  - State=DRAIN after N+1; `stall_fetch` first high in the cycle after edge N+1.
- DRAIN lasts exactly `DRAIN_CYCLES` cycles.
- Zero-wait memory (`mem_ready` tied to 1): an entry is 1 IDLE-decision cycle + `DRAIN_CYCLES` + 4 + 1 RESUME. With the default that is 9 cycles from `int_pending` to `int_ack`.
- Each `mem_ready`=0 cycle extends the current injected state by one cycle. Outputs stay stable while waiting.
- `pc_load` and `int_ack` are each exactly one cycle wide per entry.

## Test plan
- Basic entry:
  - Stimulus: reset, release, pulse `interrupt_signal` for one cycle with `pc_in`=32'h0001_2345, `flags_in`=4'b1010, `mem_ready`=1.
  - Required: `push_data` sequence 16'h0001, 16'h2345, 16'h000A.
  - Then one LOAD_VEC cycle with `mem_addr`=0 and `pc_load`=1.
  - `int_ack` 9 cycles after `int_pending` rises; `stall_fetch` high for exactly 7 cycles.
- Memory backpressure:
  - Stimulus: `mem_ready`=0 for 2 cycles during PUSH_LO.
  - Required: PUSH_LO lasts 3 cycles with `push_data` stable at 16'h2345; `int_ack` is delayed by 2 cycles.
- Nested edge:
  - Stimulus: second rising edge during PUSH_HI.
  - Required: first sequence completes; one IDLE cycle; second full sequence starts; `int_ack` pulses twice.
- Held level:
  - Stimulus: `interrupt_signal` high for 30 cycles.
  - Required: exactly one `int_ack`.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously during PUSH_LO, with no clock edge.
  - Required: `busy`, `stall_fetch` and `mem_push` drop to 0 immediately; no `int_ack` after release without a new edge.
- Parameter sweep:
  - Stimulus: `DRAIN_CYCLES`=1 and `DRAIN_CYCLES`=15.
  - Required: DRAIN is observed for 1 and 15 cycles respectively.
